// File: rtl/uart_pkg.sv
// Shared types and line levels for the lab UART link.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/flex_counter.sv
// Wrapping counter 0..rollover_val with synchronous clear; flags the last count.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (count_enable) begin
      count_next = (count == rollover_val) ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign rollover_flag = count_enable && (count == rollover_val);

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, stop bit.
// Handshake: tx_start is taken only while tx_busy=0; tx_data is captured in that same cycle.
module uart_tx_block
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);

  tx_state_t            state;
  tx_state_t            state_next;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_next;
  logic [CW-1:0]        bit_cnt;
  logic [CW-1:0]        bit_cnt_next;
  logic                 serial_next;
  logic                 busy_next;
  logic                 done_next;
  logic                 accept;
  logic                 timer_en;
  logic                 tick;

  assign accept   = (state == IDLE) && tx_start;
  assign timer_en = (state != IDLE);

  flex_counter #(
    .WIDTH(TW)
  ) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (accept),
    .count_enable (timer_en),
    .rollover_val (LAST_TICK),
    .rollover_flag(tick)
  );

  // Outputs are computed one cycle ahead so they can come straight from flops.
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    bit_cnt_next = bit_cnt;
    serial_next  = serial_out;
    busy_next    = tx_busy;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        serial_next = IDLE_LEVEL;
        busy_next   = 1'b0;
        if (tx_start) begin
          shift_next  = tx_data;
          state_next  = START;
          serial_next = START_LEVEL;
          busy_next   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_cnt_next = '0;
          serial_next  = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_next   = shift_q >> 1;
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_next  = STOP;
            serial_next = STOP_LEVEL;
          end else begin
            serial_next = shift_q[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_next  = IDLE;
          serial_next = IDLE_LEVEL;
          busy_next   = 1'b0;
          done_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      serial_out <= IDLE_LEVEL;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      shift_q    <= shift_next;
      bit_cnt    <= bit_cnt_next;
      serial_out <= serial_next;
      tx_busy    <= busy_next;
      tx_done    <= done_next;
    end
  end

endmodule
